hazard_tracker: RTL and testbench
=================================

# hazard_tracker

Pipeline hazard tracker for the 5-stage ARM core. It keeps a shadow copy of the destination-register state of the EXE, MEM and WB stages, and advances it in lockstep with the real pipeline. From that state it drives the `mem_dest`/`wb_dest` write-back qualifiers the forwarding logic consumes. It also raises a stall (`hazard`) toward IF/ID whenever an ID-stage source cannot be satisfied by forwarding or by the register file.

## Interface
Parameters:
- `ADDR_LEN`, default `` `REGISTER_FILE_ADDRESS_LEN `` (4): register address width.
- `STAT_W`, default 16: stall-counter width (used only with the macro).

Ports (name, direction, width, meaning). Reset is synchronous and active-high.
- `clk`, in, 1: core clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous active-high reset.
- `forwarding_enable`, in, 1: forwarding datapath active.
- `freeze`, in, 1: global pipeline hold (memory wait); shadow state holds.
- `flush`, in, 1: branch taken in EXE; the ID instruction is discarded.
- `id_valid`, in, 1: ID holds a real instruction.
- `id_src1`, in, `ADDR_LEN`: Rn of the ID instruction.
- `id_src2`, in, `ADDR_LEN`: Rm or Rd (store) of the ID instruction.
- `id_src1_en`, in, 1: `id_src1` is read.
- `id_src2_en`, in, 1: `id_src2` is read.
- `id_wb_en`, in, 1: ID instruction writes a register.
- `id_mem_r_en`, in, 1: ID instruction is a load.
- `id_dest`, in, `ADDR_LEN`: destination of the ID instruction.
- `hazard`, out, 1: stall IF/ID and insert a bubble into EXE (combinational).
- `mem_wb_en`, out, 1: MEM-stage instruction writes back (registered).
- `mem_dest`, out, `ADDR_LEN`: MEM-stage destination (registered).
- `wb_wb_en`, out, 1: WB-stage instruction writes back (registered).
- `wb_dest`, out, `ADDR_LEN`: WB-stage destination (registered).
- `stall_count`, out, `STAT_W`: stall statistics (macro only).

## Operation
- Three shadow slots: S_EXE, S_MEM, S_WB. Each slot holds {v, wb_en, mem_r_en, dest}.
- A slot with v=0 is a bubble. A bubble never matches and never drives write-back.
- Match(slot, src, en) = en & id_valid & slot.v & slot.wb_en & (slot.dest == src).
- Hazard with forwarding_enable=0:
  - `hazard` = 1 if any used source matches S_EXE or S_MEM.
  - S_WB is never a hazard: the register file writes in the first half-cycle.
- Hazard with forwarding_enable=1:
  - `hazard` = 1 only on a load-use match: a used source matches S_EXE and S_EXE.mem_r_en=1.
  - Matches in S_MEM or S_WB are resolved by forwarding.
- Advance, when freeze=0, all slots update simultaneously:
  - S_WB ← S_MEM.
  - S_MEM ← S_EXE.
  - S_EXE ← ID fields with v=1, only if id_valid & !hazard & !flush.
  - Otherwise S_EXE ← bubble.
- freeze=1: all slots hold. `hazard` is still evaluated from the held state.
- flush and hazard together: a bubble enters S_EXE, and flush wins.
- Outputs:
  - `mem_wb_en` = S_MEM.v & S_MEM.wb_en; `mem_dest` = S_MEM.dest.
  - `wb_wb_en` = S_WB.v & S_WB.wb_en; `wb_dest` = S_WB.dest.
- Slot valid flags form the only state machine. There is no other FSM.

## Timing
- Reset (rst=1 at a rising edge):
  - All slot fields clear to 0 (all slots become bubbles).
  - `mem_wb_en`, `mem_dest`, `wb_wb_en` and `wb_dest` are 0 on the following cycle.
  - `hazard` is 0 while the slots are bubbles.
  - `stall_count` clears to 0.
  - Reset overrides freeze and flush.
- Reset mid-stream discards all in-flight entries. There is no residual stall after reset.
- `hazard` has zero latency: it is combinational from the ID inputs and registered slots.
- An instruction accepted at edge N appears on `mem_*` after edge N+1 and on `wb_*` after edge N+2, absent freeze.
- Load-use stall with forwarding lasts exactly 1 cycle.
- Without forwarding, a dependent instruction stalls:
  - 2 cycles behind a producer just accepted into S_EXE;
  - 1 cycle behind a producer in S_MEM.

## Configuration
- Macro `HAZARD_STATS_EN`.
- Defined:
  - `stall_count` increments by 1 on each edge where hazard & !freeze & !rst.
  - It saturates at all-ones and never wraps.
- Undefined:
  - The `stall_count` port and the counter are absent.
  - Behaviour is otherwise identical.

## Test plan
- Reset: hold rst 2 cycles with random inputs → all outputs 0; no hazard on the first id_valid.
- Load-use, forwarding=1: accept LDR R3 (id_mem_r_en=1, dest 3), then ADD with src1=3.
  - Required: `hazard`=1 for exactly 1 cycle.
  - Next cycle: `mem_dest`=3, `mem_wb_en`=1, `hazard`=0.
- No forwarding: accept MOV R5, then SUB using src2=5 with forwarding_enable=0.
  - Required: `hazard` high 2 cycles.
  - The SUB enters S_EXE on cycle 3.
  - `wb_dest`=5 and `wb_wb_en`=1 when the SUB is accepted.
- Freeze: assert freeze 3 cycles with R7 producer in S_EXE and a dependent load-use consumer in ID.
  - Required: slots hold and `hazard` stays 1 throughout.
  - After release: one stall cycle, then the consumer is accepted.
- Flush: flush=1 with a valid ID write to R2.
  - Required: a bubble enters S_EXE.
  - Two cycles later, `mem_wb_en`=0.
  - No hazard is raised for a later reader of R2.
- Stats (`HAZARD_STATS_EN`), with `STAT_W`=4:
  - Force hazard for 20 unfrozen cycles → `stall_count`=15 (saturated).
  - Apply rst → `stall_count`=0.

Source files
------------

// File: rtl/hazard_tracker.sv
`default_nettype none
// hazard_tracker: shadow EXE/MEM/WB destination slots, write-back qualifiers and ID-stage stall detection.
// Optional macro HAZARD_STATS_EN adds a saturating stall counter on stall_count.

`ifndef REGISTER_FILE_ADDRESS_LEN
`define REGISTER_FILE_ADDRESS_LEN 4
`endif

module hazard_tracker #(
  parameter int ADDR_LEN = `REGISTER_FILE_ADDRESS_LEN,
  parameter int STAT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                forwarding_enable,
  input  logic                freeze,
  input  logic                flush,
  input  logic                id_valid,
  input  logic [ADDR_LEN-1:0] id_src1,
  input  logic [ADDR_LEN-1:0] id_src2,
  input  logic                id_src1_en,
  input  logic                id_src2_en,
  input  logic                id_wb_en,
  input  logic                id_mem_r_en,
  input  logic [ADDR_LEN-1:0] id_dest,
  output logic                hazard,
  output logic                mem_wb_en,
  output logic [ADDR_LEN-1:0] mem_dest,
  output logic                wb_wb_en,
  output logic [ADDR_LEN-1:0] wb_dest
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0]   stall_count
`endif
);

  if (STAT_W < 1) begin : g_stat_w_check
    $error("hazard_tracker: STAT_W must be at least 1");
  end

  typedef struct packed {
    logic                v;
    logic                wb_en;
    logic                mem_r_en;
    logic [ADDR_LEN-1:0] dest;
  } exe_slot_t;

  // The load flag only matters while the producer sits in EXE, so later slots drop it.
  typedef struct packed {
    logic                v;
    logic                wb_en;
    logic [ADDR_LEN-1:0] dest;
  } wb_slot_t;

  exe_slot_t exe_q, exe_d;
  wb_slot_t  mem_q, wb_q;
  logic      exe_hit;
  logic      mem_hit;

  function automatic logic src_match(input logic                slot_v,
                                     input logic                slot_wb_en,
                                     input logic [ADDR_LEN-1:0] slot_dest,
                                     input logic [ADDR_LEN-1:0] src,
                                     input logic                en,
                                     input logic                valid);
    return en & valid & slot_v & slot_wb_en & (slot_dest == src);
  endfunction

  always_comb begin
    exe_hit = src_match(exe_q.v, exe_q.wb_en, exe_q.dest, id_src1, id_src1_en, id_valid)
            | src_match(exe_q.v, exe_q.wb_en, exe_q.dest, id_src2, id_src2_en, id_valid);
    mem_hit = src_match(mem_q.v, mem_q.wb_en, mem_q.dest, id_src1, id_src1_en, id_valid)
            | src_match(mem_q.v, mem_q.wb_en, mem_q.dest, id_src2, id_src2_en, id_valid);
    // WB never stalls: the register file writes in the first half-cycle.
    if (forwarding_enable) begin
      hazard = exe_hit & exe_q.mem_r_en;
    end else begin
      hazard = exe_hit | mem_hit;
    end
  end

  always_comb begin
    exe_d = '0;
    if (id_valid && !hazard && !flush) begin
      exe_d.v        = 1'b1;
      exe_d.wb_en    = id_wb_en;
      exe_d.mem_r_en = id_mem_r_en;
      exe_d.dest     = id_dest;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_q <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!freeze) begin
      exe_q <= exe_d;
      mem_q <= '{v: exe_q.v, wb_en: exe_q.wb_en, dest: exe_q.dest};
      wb_q  <= mem_q;
    end
  end

  assign mem_wb_en = mem_q.v & mem_q.wb_en;
  assign mem_dest  = mem_q.dest;
  assign wb_wb_en  = wb_q.v & wb_q.wb_en;
  assign wb_dest   = wb_q.dest;

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (hazard && !freeze && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + STAT_W'(1);
    end
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_tracker.sv
`default_nettype none
// tb_hazard_tracker: directed scenarios plus randomized traffic checked against a
// slot-list reference model of the hazard tracker.

module tb_hazard_tracker;

  localparam int AW     = 4;
  localparam int SW     = 4;
  localparam int SATMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          forwarding_enable;
  logic          freeze;
  logic          flush;
  logic          id_valid;
  logic [AW-1:0] id_src1;
  logic [AW-1:0] id_src2;
  logic          id_src1_en;
  logic          id_src2_en;
  logic          id_wb_en;
  logic          id_mem_r_en;
  logic [AW-1:0] id_dest;
  logic          hazard;
  logic          mem_wb_en;
  logic [AW-1:0] mem_dest;
  logic          wb_wb_en;
  logic [AW-1:0] wb_dest;
`ifdef HAZARD_STATS_EN
  logic [SW-1:0] stall_count;
`endif

  hazard_tracker #(.ADDR_LEN(AW), .STAT_W(SW)) dut (
    .clk               (clk),
    .rst               (rst),
    .forwarding_enable (forwarding_enable),
    .freeze            (freeze),
    .flush             (flush),
    .id_valid          (id_valid),
    .id_src1           (id_src1),
    .id_src2           (id_src2),
    .id_src1_en        (id_src1_en),
    .id_src2_en        (id_src2_en),
    .id_wb_en          (id_wb_en),
    .id_mem_r_en       (id_mem_r_en),
    .id_dest           (id_dest),
    .hazard            (hazard),
    .mem_wb_en         (mem_wb_en),
    .mem_dest          (mem_dest),
    .wb_wb_en          (wb_wb_en),
    .wb_dest           (wb_dest)
`ifdef HAZARD_STATS_EN
    ,
    .stall_count       (stall_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a plain list of in-flight instructions, index 0 = EXE, 1 = MEM, 2 = WB.
  typedef struct {
    bit v;
    bit wb;
    bit ld;
    int dest;
  } ent_t;

  ent_t m_pipe [3];
  int   m_cnt;
  bit   exp_hz;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) m_pipe[k] = '{v: 0, wb: 0, ld: 0, dest: 0};
    m_cnt = 0;
  endfunction

  function automatic bit model_hazard();
    bit hz = 0;
    for (int k = 0; k < 2; k++) begin
      int s  = (k == 0) ? int'(id_src1) : int'(id_src2);
      bit en = (k == 0) ? id_src1_en : id_src2_en;
      if (en && id_valid) begin
        if (m_pipe[0].v && m_pipe[0].wb && m_pipe[0].dest == s)
          if (!forwarding_enable || m_pipe[0].ld) hz = 1;
        if (!forwarding_enable && m_pipe[1].v && m_pipe[1].wb && m_pipe[1].dest == s)
          hz = 1;
      end
    end
    return hz;
  endfunction

  task automatic sample();
    @(negedge clk);
    exp_hz = model_hazard();
    check_eq("hazard", {31'd0, hazard}, {31'd0, exp_hz});
    check_eq("mem_wb_en", {31'd0, mem_wb_en}, {31'd0, m_pipe[1].v & m_pipe[1].wb});
    if (m_pipe[1].v && m_pipe[1].wb) check_eq("mem_dest", 32'(mem_dest), 32'(m_pipe[1].dest));
    check_eq("wb_wb_en", {31'd0, wb_wb_en}, {31'd0, m_pipe[2].v & m_pipe[2].wb});
    if (m_pipe[2].v && m_pipe[2].wb) check_eq("wb_dest", 32'(wb_dest), 32'(m_pipe[2].dest));
`ifdef HAZARD_STATS_EN
    check_eq("stall_count", 32'(stall_count), 32'(m_cnt));
`endif
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (!freeze) begin
      if (exp_hz && m_cnt < SATMAX) m_cnt++;
      m_pipe[2] = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      if (id_valid && !exp_hz && !flush)
        m_pipe[0] = '{v: 1, wb: id_wb_en, ld: id_mem_r_en, dest: int'(id_dest)};
      else
        m_pipe[0] = '{v: 0, wb: 0, ld: 0, dest: 0};
    end
    #1;
  endtask

  task automatic set_id(input bit v, input int s1, input bit e1, input int s2, input bit e2,
                        input bit wb, input bit ld, input int d);
    id_valid    = v;
    id_src1     = AW'(s1);
    id_src1_en  = e1;
    id_src2     = AW'(s2);
    id_src2_en  = e2;
    id_wb_en    = wb;
    id_mem_r_en = ld;
    id_dest     = AW'(d);
  endtask

  task automatic randomize_id(input int max_reg);
    set_id($urandom_range(0, 1), $urandom_range(0, max_reg), $urandom_range(0, 1),
           $urandom_range(0, max_reg), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, max_reg));
  endtask

  task automatic drain();
    freeze = 0;
    flush  = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) begin
      sample();
      advance();
    end
  endtask

  initial begin
    rst = 1;
    forwarding_enable = $urandom_range(0, 1);
    freeze = $urandom_range(0, 1);
    flush  = $urandom_range(0, 1);
    randomize_id(15);
    @(posedge clk);
    #1;
    model_reset();
    randomize_id(15);
    sample();
    check_eq("rst_mem_wb_en", {31'd0, mem_wb_en}, 32'd0);
    check_eq("rst_mem_dest", 32'(mem_dest), 32'd0);
    check_eq("rst_wb_wb_en", {31'd0, wb_wb_en}, 32'd0);
    check_eq("rst_wb_dest", 32'(wb_dest), 32'd0);
    check_eq("rst_hazard", {31'd0, hazard}, 32'd0);
    advance();
    rst = 0;
    freeze = 0;
    flush  = 0;
    forwarding_enable = 0;
    set_id(1, 1, 1, 2, 1, 1, 0, 1);
    sample();
    check_eq("first_id_no_hz", {31'd0, hazard}, 32'd0);
    advance();

    // Load-use with forwarding.
    drain();
    forwarding_enable = 1;
    set_id(1, 0, 0, 0, 0, 1, 1, 3);
    sample();
    advance();
    set_id(1, 3, 1, 9, 1, 1, 0, 4);
    sample();
    check_eq("lu_stall", {31'd0, hazard}, 32'd1);
    advance();
    sample();
    check_eq("lu_release", {31'd0, hazard}, 32'd0);
    check_eq("lu_mem_dest", 32'(mem_dest), 32'd3);
    check_eq("lu_mem_wb_en", {31'd0, mem_wb_en}, 32'd1);
    advance();

    // No forwarding: two-cycle stall behind a fresh producer.
    drain();
    forwarding_enable = 0;
    set_id(1, 0, 0, 0, 0, 1, 0, 5);
    sample();
    advance();
    set_id(1, 8, 1, 5, 1, 1, 0, 6);
    for (int c = 0; c < 2; c++) begin
      sample();
      check_eq("nf_stall", {31'd0, hazard}, 32'd1);
      advance();
    end
    sample();
    check_eq("nf_accept", {31'd0, hazard}, 32'd0);
    check_eq("nf_wb_dest", 32'(wb_dest), 32'd5);
    check_eq("nf_wb_wb_en", {31'd0, wb_wb_en}, 32'd1);
    advance();

    // Freeze holds a load-use stall.
    drain();
    forwarding_enable = 1;
    set_id(1, 0, 0, 0, 0, 1, 1, 7);
    sample();
    advance();
    set_id(1, 7, 1, 0, 0, 1, 0, 8);
    freeze = 1;
    for (int c = 0; c < 3; c++) begin
      sample();
      check_eq("frz_hz", {31'd0, hazard}, 32'd1);
      check_eq("frz_mem_wb_en", {31'd0, mem_wb_en}, 32'd0);
      advance();
    end
    freeze = 0;
    sample();
    check_eq("frz_post_stall", {31'd0, hazard}, 32'd1);
    advance();
    sample();
    check_eq("frz_accept", {31'd0, hazard}, 32'd0);
    check_eq("frz_mem_dest", 32'(mem_dest), 32'd7);
    advance();

    // Flush discards the ID write to R2.
    drain();
    forwarding_enable = 0;
    set_id(1, 0, 0, 0, 0, 1, 0, 2);
    flush = 1;
    sample();
    advance();
    flush = 0;
    set_id(1, 2, 1, 2, 1, 0, 0, 0);
    sample();
    check_eq("fl_no_hz", {31'd0, hazard}, 32'd0);
    advance();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    check_eq("fl_mem_wb_en", {31'd0, mem_wb_en}, 32'd0);
    advance();

`ifdef HAZARD_STATS_EN
    rst = 1;
    sample();
    advance();
    rst = 0;
    forwarding_enable = 0;
    set_id(1, 1, 1, 0, 0, 1, 0, 1);
    repeat (32) begin
      sample();
      advance();
    end
    sample();
    check_eq("stat_sat", 32'(stall_count), 32'(SATMAX));
    advance();
    rst = 1;
    sample();
    advance();
    rst = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    check_eq("stat_clr", 32'(stall_count), 32'd0);
    advance();
`endif

    // Randomized traffic over a small register set to provoke dependencies.
    for (int c = 0; c < 600; c++) begin
      rst               = ($urandom_range(0, 99) < 2);
      freeze            = ($urandom_range(0, 99) < 15);
      flush             = ($urandom_range(0, 99) < 10);
      forwarding_enable = (c % 150) < 75;
      randomize_id(3);
      sample();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
